// File: rtl/icache_dump_reader.sv
// icache_dump_reader: streams {address, data} read back from the instruction SRAM over valid/ready
module icache_dump_reader #(
  parameter int D_WIDTH  = 32,
  parameter int SA_WIDTH = 10
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Start,
  input  logic                Abort,
  input  logic [SA_WIDTH-1:0] Base_Addr,
  input  logic [SA_WIDTH:0]   Count,
  output logic                M_enb,
  output logic                M_web,
  output logic [SA_WIDTH-1:0] MI_Addr,
  input  logic [D_WIDTH-1:0]  MO_do,
  output logic                Out_Valid,
  input  logic                Out_Ready,
  output logic [D_WIDTH-1:0]  Out_Data,
  output logic [SA_WIDTH-1:0] Out_Addr,
  output logic                Busy,
  output logic                Done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [SA_WIDTH:0]   rem;
  logic [SA_WIDTH-1:0] nxt_addr, hold_addr, fl_addr;
  logic                inflight;
  logic [D_WIDTH-1:0]  f_data [2];
  logic [SA_WIDTH-1:0] f_addr [2];
  logic                rp, wp;
  logic [1:0]          cnt;
  logic                pop, issue, last, go, done_nxt;
  // Next state, issue credit and completion detection
  always_comb begin
    state_nxt = state;
    pop       = Out_Valid && Out_Ready;
    go        = (state == IDLE) && Start && !Abort;
    issue     = (state == RUN) && !Abort && (rem != '0) &&
                (cnt + 2'(inflight) - 2'(pop) < 2'd2);
    last      = pop && (rem == '0) && !inflight && (cnt == 2'd1);
    done_nxt  = (state == IDLE) ? go && (Count == '0) : last && !Abort;
    if (state == IDLE && go && Count != '0) state_nxt = RUN;
    if (state == RUN && (Abort || last)) state_nxt = IDLE;
  end
  assign M_enb     = issue;
  assign M_web     = 1'b0;
  assign MI_Addr   = issue ? nxt_addr : hold_addr;
  assign Out_Valid = cnt != 2'd0;
  assign Out_Data  = f_data[rp];
  assign Out_Addr  = f_addr[rp];
  assign Busy      = state == RUN;
  // State register and one-cycle completion pulse
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      Done  <= done_nxt;
    end
  end
  // Read issue: remaining words, next address and the tag of the read in flight
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rem       <= '0;
      nxt_addr  <= '0;
      hold_addr <= '0;
      fl_addr   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      if (go && Count != '0) begin
        rem      <= Count;
        nxt_addr <= Base_Addr;
      end else if (issue) begin
        rem       <= rem - (SA_WIDTH+1)'(1);
        nxt_addr  <= nxt_addr + SA_WIDTH'(1);
        hold_addr <= nxt_addr;
        fl_addr   <= nxt_addr;
      end
    end
  end
  // Two-entry output FIFO; Abort flushes it and drops the returning read
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      f_data[0] <= '0;
      f_data[1] <= '0;
      f_addr[0] <= '0;
      f_addr[1] <= '0;
      rp        <= 1'b0;
      wp        <= 1'b0;
      cnt       <= 2'd0;
    end else if (Abort) begin
      rp  <= 1'b0;
      wp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (inflight) begin
        f_data[wp] <= MO_do;
        f_addr[wp] <= fl_addr;
        wp         <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(inflight) - 2'(pop);
    end
  end
endmodule
